cu_res_alloc_ctrl: RTL and testbench
====================================

Name: cu_res_alloc_ctrl

Overview:
- Dispatcher control stage wrapped around one CU-resource CAM.
- Accepts workgroup allocation requests and drives the CAM search port (res_search_en/size).
- Consumes the CAM's per-CU fit mask, picks one CU and keeps a shadow free-slot table.
- Writes the CU's updated free count back into the CAM; also returns resources on deallocation.

Parameters:
CU_ID_WIDTH, 6, width of CU index
NUMBER_CU, 64, number of CUs (CAM entries)
RES_ID_WIDTH, 10, resource index width; counts/sizes are RES_ID_WIDTH+1 bits
NUMBER_RES_SLOTS, 1024, slots per CU; free count of a never-written CU

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
alloc_req_valid  in  1  allocation request
alloc_req_size  in  RES_ID_WIDTH+1  slots requested
alloc_req_ready  out  1  request accepted when valid&ready
alloc_resp_valid  out  1  one-cycle response pulse
alloc_resp_ok  out  1  1=granted, 0=no CU fits
alloc_resp_cu  out  CU_ID_WIDTH  granted CU (0 when !ok)
dealloc_valid  in  1  release request
dealloc_cu  in  CU_ID_WIDTH  CU releasing
dealloc_size  in  RES_ID_WIDTH+1  slots released
dealloc_ready  out  1  release accepted when valid&ready
dealloc_err  out  1  one-cycle pulse, release overflowed
res_search_en  out  1  to CAM search enable
res_search_size  out  RES_ID_WIDTH+1  to CAM search size
res_search_out  in  NUMBER_CU  CAM fit mask, valid the cycle after res_search_en
cam_wr_en  out  1  CAM write enable
cam_wr_addr  out  CU_ID_WIDTH  CAM write index
cam_wr_data  out  RES_ID_WIDTH+1  new free count

Behaviour:
- Shadow table free[NUMBER_CU] plus a valid bit per CU.
- Reset clears all valid bits. An invalid CU reads as NUMBER_RES_SLOTS free, matching the CAM's treatment of unwritten entries.
- Reset state: IDLE. All outputs 0 except alloc_req_ready=1 and dealloc_ready=1. RR pointer 0.
- FSM states: IDLE, SEARCH, CHECK, WRITE, DEALLOC.
- IDLE:
  - Both ready outputs are 1.
  - If dealloc_valid: latch cu/size, go DEALLOC. Dealloc has priority; alloc_req_ready is driven 0 that cycle.
  - Else if alloc_req_valid: latch size, go SEARCH.
- SEARCH (1 cycle): res_search_en=1, res_search_size=latched size. Go CHECK.
- CHECK (1 cycle): sample res_search_out.
  - If zero: alloc_resp_valid=1, ok=0, cu=0; go IDLE.
  - Else: select winner, register it, go WRITE.
- WRITE (1 cycle):
  - cam_wr_en=1, cam_wr_addr=winner, cam_wr_data=free[winner]-size.
  - Update shadow table, set valid.
  - alloc_resp_valid=1, ok=1, cu=winner. Advance RR pointer to winner+1 mod NUMBER_CU. Go IDLE.
- DEALLOC (1 cycle):
  - new = free[cu]+size, computed RES_ID_WIDTH+2 bits wide.
  - If new > NUMBER_RES_SLOTS: clamp to NUMBER_RES_SLOTS and pulse dealloc_err.
  - Write CAM and shadow table, set valid. Go IDLE.
- Latency:
  - Alloc: accept at T, search T+1, response T+3 (grant) or T+2 (fail).
  - Dealloc: accept at T, write T+1.
- Min spacing between two allocs is 4 cycles. A CAM write lands before the next search's mask is sampled, so there is no stale-mask hazard.
- size=0: CAM mask is all-ones; grant proceeds and writes free unchanged.
- Subtraction never underflows, because the mask guarantees free>=size. A mask bit set for a CU whose shadow free < size is a CAM/shadow mismatch. It is tolerated with result saturated to 0.
- Ready outputs are 0 outside IDLE; inputs are ignored there.
- rst asserted in any state returns to IDLE next edge. An in-flight request is dropped with no response and no CAM write.

Optional Feature:
CU_ALLOC_ROUND_ROBIN_EN
- Defined: winner is the first set mask bit at or above the RR pointer, wrapping to index 0.
- Undefined: fixed priority, lowest set index wins; no pointer register.

Test Plan:
- Reset, alloc size 100 with CAM mask all-ones -> search_en at T+1 with size 100; at T+3 cam_wr CU0 data 924, resp ok=1 cu=0.
- Four allocs size 1000 with RR enabled and mask from a CAM model -> grants CU0,1,2,3. Fixed-priority build: grants CU0, then CU1 (CU0 left 24).
- Mask all-zero on request size 1024 after all CUs are partly used -> resp_valid at T+2, ok=0, cu=0, no cam_wr_en.
- Dealloc CU5 size 50 and alloc request in the same cycle -> dealloc taken first (cam_wr CU5); alloc_req_ready=0 that cycle; alloc then accepted in the next IDLE.
- Dealloc CU7 size 10 on a never-allocated CU -> cam_wr_data=1024, dealloc_err pulses 1 cycle.
- rst asserted while in CHECK -> no resp_valid, no cam_wr_en; IDLE and both ready=1 the next cycle.

Source files
------------

// File: rtl/cu_res_alloc_ctrl.sv
// Dispatcher control stage around one CU-resource CAM: allocates workgroup slots, keeps a shadow free table.
// Optional macro CU_ALLOC_ROUND_ROBIN_EN selects round-robin winner choice instead of fixed lowest-index priority.
module cu_res_alloc_ctrl #(
  parameter int CU_ID_WIDTH      = 6,
  parameter int NUMBER_CU        = 64,
  parameter int RES_ID_WIDTH     = 10,
  parameter int NUMBER_RES_SLOTS = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_req_valid,
  input  logic [RES_ID_WIDTH:0]     alloc_req_size,
  output logic                      alloc_req_ready,
  output logic                      alloc_resp_valid,
  output logic                      alloc_resp_ok,
  output logic [CU_ID_WIDTH-1:0]    alloc_resp_cu,
  input  logic                      dealloc_valid,
  input  logic [CU_ID_WIDTH-1:0]    dealloc_cu,
  input  logic [RES_ID_WIDTH:0]     dealloc_size,
  output logic                      dealloc_ready,
  output logic                      dealloc_err,
  output logic                      res_search_en,
  output logic [RES_ID_WIDTH:0]     res_search_size,
  input  logic [NUMBER_CU-1:0]      res_search_out,
  output logic                      cam_wr_en,
  output logic [CU_ID_WIDTH-1:0]    cam_wr_addr,
  output logic [RES_ID_WIDTH:0]     cam_wr_data
);

  localparam int CW = RES_ID_WIDTH + 1;
  localparam logic [CW-1:0] FULL = CW'(NUMBER_RES_SLOTS);

  typedef enum logic [2:0] {IDLE, SEARCH, CHECK, WRITE, DEALLOC} state_t;

  state_t                 state;
  logic                   ready_q;
  logic [CW-1:0]          size_q;
  logic [CW-1:0]          free_tbl [NUMBER_CU];
  logic [NUMBER_CU-1:0]   valid_tbl;
  logic [CU_ID_WIDTH-1:0] start_idx;
  logic [CU_ID_WIDTH-1:0] pick;
  logic [CW-1:0]          win_free;
  logic [CW-1:0]          win_new;
  logic [CW-1:0]          dealloc_free;
  logic [CW:0]            dealloc_sum;
  logic                   fail_now;

`ifdef CU_ALLOC_ROUND_ROBIN_EN
  logic [CU_ID_WIDTH-1:0] rr_ptr;
  assign start_idx = rr_ptr;
`else
  assign start_idx = '0;
`endif

  // First set mask bit at or above start, wrapping; index wraps naturally since NUMBER_CU == 2**CU_ID_WIDTH.
  function automatic logic [CU_ID_WIDTH-1:0] pick_cu(input logic [NUMBER_CU-1:0] mask,
                                                     input logic [CU_ID_WIDTH-1:0] start);
    logic [CU_ID_WIDTH-1:0] idx;
    logic found;
    pick_cu = '0;
    found   = 1'b0;
    for (int i = 0; i < NUMBER_CU; i++) begin
      idx = start + CU_ID_WIDTH'(i);
      if (!found && mask[idx]) begin
        pick_cu = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign pick         = pick_cu(res_search_out, start_idx);
  assign win_free     = valid_tbl[pick] ? free_tbl[pick] : FULL;
  // A mask bit on a CU the shadow says is too small is a CAM/shadow mismatch; saturate rather than wrap.
  assign win_new      = (win_free >= size_q) ? (win_free - size_q) : '0;
  assign dealloc_free = valid_tbl[dealloc_cu] ? free_tbl[dealloc_cu] : FULL;
  assign dealloc_sum  = {1'b0, dealloc_free} + {1'b0, dealloc_size};

  // A failed search answers in the CHECK cycle itself, so it is decoded from the live mask.
  assign fail_now         = (state == CHECK) && (res_search_out == '0) && !rst;
  assign alloc_resp_valid = (state == WRITE) || fail_now;
  assign alloc_resp_ok    = (state == WRITE);
  assign alloc_resp_cu    = (state == WRITE) ? cam_wr_addr : '0;
  assign alloc_req_ready  = ready_q && !dealloc_valid;
  assign dealloc_ready    = ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ready_q         <= 1'b1;
      size_q          <= '0;
      valid_tbl       <= '0;
      res_search_en   <= 1'b0;
      res_search_size <= '0;
      cam_wr_en       <= 1'b0;
      cam_wr_addr     <= '0;
      cam_wr_data     <= '0;
      dealloc_err     <= 1'b0;
`ifdef CU_ALLOC_ROUND_ROBIN_EN
      rr_ptr          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (dealloc_valid) begin
            ready_q     <= 1'b0;
            cam_wr_en   <= 1'b1;
            cam_wr_addr <= dealloc_cu;
            if (dealloc_sum > {1'b0, FULL}) begin
              cam_wr_data <= FULL;
              dealloc_err <= 1'b1;
            end else begin
              cam_wr_data <= dealloc_sum[CW-1:0];
            end
            state <= DEALLOC;
          end else if (alloc_req_valid) begin
            ready_q         <= 1'b0;
            size_q          <= alloc_req_size;
            res_search_en   <= 1'b1;
            res_search_size <= alloc_req_size;
            state           <= SEARCH;
          end
        end
        SEARCH: begin
          res_search_en   <= 1'b0;
          res_search_size <= '0;
          state           <= CHECK;
        end
        CHECK: begin
          if (res_search_out == '0) begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            cam_wr_en   <= 1'b1;
            cam_wr_addr <= pick;
            cam_wr_data <= win_new;
            state       <= WRITE;
          end
        end
        WRITE: begin
          free_tbl[cam_wr_addr]  <= cam_wr_data;
          valid_tbl[cam_wr_addr] <= 1'b1;
          cam_wr_en              <= 1'b0;
`ifdef CU_ALLOC_ROUND_ROBIN_EN
          rr_ptr <= (cam_wr_addr == CU_ID_WIDTH'(NUMBER_CU - 1)) ? '0 : cam_wr_addr + 1'b1;
`endif
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        DEALLOC: begin
          free_tbl[cam_wr_addr]  <= cam_wr_data;
          valid_tbl[cam_wr_addr] <= 1'b1;
          cam_wr_en              <= 1'b0;
          dealloc_err            <= 1'b0;
          ready_q                <= 1'b1;
          state                  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_res_alloc_ctrl.sv
// Scoreboard bench for cu_res_alloc_ctrl: a CAM environment model plus an integer reference model of slot accounting.
module tb_cu_res_alloc_ctrl;

  localparam int CUW   = 6;
  localparam int NCU   = 64;
  localparam int RW    = 10;
  localparam int NSLOT = 1024;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            alloc_req_valid = 1'b0;
  logic [RW:0]     alloc_req_size = '0;
  logic            alloc_req_ready;
  logic            alloc_resp_valid;
  logic            alloc_resp_ok;
  logic [CUW-1:0]  alloc_resp_cu;
  logic            dealloc_valid = 1'b0;
  logic [CUW-1:0]  dealloc_cu = '0;
  logic [RW:0]     dealloc_size = '0;
  logic            dealloc_ready;
  logic            dealloc_err;
  logic            res_search_en;
  logic [RW:0]     res_search_size;
  logic [NCU-1:0]  res_search_out;
  logic            cam_wr_en;
  logic [CUW-1:0]  cam_wr_addr;
  logic [RW:0]     cam_wr_data;

  always #5 clk = ~clk;

  cu_res_alloc_ctrl #(.CU_ID_WIDTH(CUW), .NUMBER_CU(NCU), .RES_ID_WIDTH(RW), .NUMBER_RES_SLOTS(NSLOT)) dut (
    .clk(clk), .rst(rst),
    .alloc_req_valid(alloc_req_valid), .alloc_req_size(alloc_req_size), .alloc_req_ready(alloc_req_ready),
    .alloc_resp_valid(alloc_resp_valid), .alloc_resp_ok(alloc_resp_ok), .alloc_resp_cu(alloc_resp_cu),
    .dealloc_valid(dealloc_valid), .dealloc_cu(dealloc_cu), .dealloc_size(dealloc_size),
    .dealloc_ready(dealloc_ready), .dealloc_err(dealloc_err),
    .res_search_en(res_search_en), .res_search_size(res_search_size), .res_search_out(res_search_out),
    .cam_wr_en(cam_wr_en), .cam_wr_addr(cam_wr_addr), .cam_wr_data(cam_wr_data)
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int a; int b; int c; } exp_t;
  exp_t srch_q[$];
  exp_t wr_q[$];
  exp_t resp_q[$];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // CAM environment: registered fit mask one cycle after search, optional forced mask.
  int             cam_free [NCU];
  logic [NCU-1:0] cam_mask = '0;
  bit             ovr_en = 1'b0;
  logic [NCU-1:0] ovr_mask = '0;

  function automatic logic [NCU-1:0] cam_fit(input int size);
    logic [NCU-1:0] m;
    for (int k = 0; k < NCU; k++) m[k] = (cam_free[k] >= size);
    return m;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (cam_free[k]) cam_free[k] <= NSLOT;
      cam_mask <= '0;
    end else begin
      if (cam_wr_en) cam_free[cam_wr_addr] <= int'(cam_wr_data);
      if (res_search_en) cam_mask <= ovr_en ? ovr_mask : cam_fit(int'(res_search_size));
    end
  end
  assign res_search_out = cam_mask;

  // Reference model: integer free counts per CU and a round-robin start index.
  int ref_free [NCU];
  int ref_rr;

  task automatic resetModel();
    foreach (ref_free[k]) ref_free[k] = NSLOT;
    ref_rr = 0;
    ovr_en = 1'b0;
  endtask

  function automatic int ref_pick(input logic [NCU-1:0] m);
`ifdef CU_ALLOC_ROUND_ROBIN_EN
    for (int k = 0; k < NCU; k++) if (m[(ref_rr + k) % NCU]) return (ref_rr + k) % NCU;
`else
    for (int k = 0; k < NCU; k++) if (m[k]) return k;
`endif
    return -1;
  endfunction

  task automatic predictAlloc(input int size, input int e);
    logic [NCU-1:0] m;
    int w, nv;
    for (int k = 0; k < NCU; k++) m[k] = (ref_free[k] >= size);
    if (ovr_en) m = ovr_mask;
    srch_q.push_back('{e, size, 0, 0});
    w = ref_pick(m);
    if (w < 0) begin
      resp_q.push_back('{e + 1, 0, 0, 0});
    end else begin
      nv = (ref_free[w] >= size) ? ref_free[w] - size : 0;
      wr_q.push_back('{e + 2, w, nv, 0});
      resp_q.push_back('{e + 2, 1, w, 0});
      ref_free[w] = nv;
      ref_rr = (w + 1) % NCU;
    end
  endtask

  task automatic predictDealloc(input int cu, input int size, input int e);
    int s;
    int err;
    s = ref_free[cu] + size;
    err = (s > NSLOT) ? 1 : 0;
    if (err == 1) s = NSLOT;
    wr_q.push_back('{e, cu, s, err});
    ref_free[cu] = s;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a search, a CAM write or a response.
  always @(negedge clk) begin
    exp_t x;
    if (cyc > 0) begin
      if (res_search_en) begin
        if (srch_q.size() == 0) checkOutput("unexpected_search", 1, 0);
        else begin
          x = srch_q.pop_front();
          checkOutput("search_cycle", cyc, x.cyc);
          checkOutput("search_size", res_search_size, x.a);
        end
      end
      if (cam_wr_en) begin
        if (wr_q.size() == 0) checkOutput("unexpected_cam_wr", 1, 0);
        else begin
          x = wr_q.pop_front();
          checkOutput("cam_wr_cycle", cyc, x.cyc);
          checkOutput("cam_wr_addr", cam_wr_addr, x.a);
          checkOutput("cam_wr_data", cam_wr_data, x.b);
          checkOutput("dealloc_err", dealloc_err, x.c);
        end
      end else if (dealloc_err) begin
        checkOutput("stray_dealloc_err", 1, 0);
      end
      if (alloc_resp_valid) begin
        if (resp_q.size() == 0) checkOutput("unexpected_resp", 1, 0);
        else begin
          x = resp_q.pop_front();
          checkOutput("resp_cycle", cyc, x.cyc);
          checkOutput("resp_ok", alloc_resp_ok, x.a);
          checkOutput("resp_cu", alloc_resp_cu, x.b);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!dealloc_ready && n < 30) begin step(); n++; end
    checkOutput("idle_timeout", dealloc_ready, 1);
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    step();
    checkOutput("rst_alloc_ready", alloc_req_ready, 1);
    checkOutput("rst_dealloc_ready", dealloc_ready, 1);
    checkOutput("rst_resp_valid", alloc_resp_valid, 0);
    checkOutput("rst_cam_wr_en", cam_wr_en, 0);
    checkOutput("rst_search_en", res_search_en, 0);
    checkOutput("rst_dealloc_err", dealloc_err, 0);
    rst = 1'b0;
    resetModel();
  endtask

  task automatic applyStimulus(input bit do_a, input int asize, input bit do_d, input int dcu, input int dsize);
    int n;
    alloc_req_valid = do_a;
    alloc_req_size  = (RW + 1)'(asize);
    dealloc_valid   = do_d;
    dealloc_cu      = CUW'(dcu);
    dealloc_size    = (RW + 1)'(dsize);
    #1;
    if (do_d) begin
      n = 0;
      while (!dealloc_ready && n < 30) begin step(); n++; end
      checkOutput("dealloc_accept", dealloc_ready, 1);
      if (do_a) checkOutput("alloc_ready_blocked", alloc_req_ready, 0);
      predictDealloc(dcu, dsize, cyc + 1);
      step();
      dealloc_valid = 1'b0;
      #1;
    end
    if (do_a) begin
      n = 0;
      while (!alloc_req_ready && n < 30) begin step(); n++; end
      checkOutput("alloc_accept", alloc_req_ready, 1);
      predictAlloc(asize, cyc + 1);
      step();
      alloc_req_valid = 1'b0;
    end
    waitIdle();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r, s, k;
    doReset();

    applyStimulus(1, 100, 0, 0, 0);

    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 1000, 0, 0, 0);

    ovr_en = 1'b1;
    ovr_mask = '0;
    applyStimulus(1, 1024, 0, 0, 0);
    ovr_en = 1'b0;

    applyStimulus(1, 300, 1, 5, 50);
    applyStimulus(0, 0, 1, 7, 10);
    applyStimulus(1, 0, 0, 0, 0);

    // Reset while the controller sits in CHECK: the request vanishes.
    alloc_req_valid = 1'b1;
    alloc_req_size  = 11'd200;
    #1;
    checkOutput("chk_rst_accept", alloc_req_ready, 1);
    srch_q.push_back('{cyc + 1, 200, 0, 0});
    step();
    alloc_req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    checkOutput("chk_rst_alloc_ready", alloc_req_ready, 1);
    checkOutput("chk_rst_dealloc_ready", dealloc_ready, 1);
    checkOutput("chk_rst_resp_valid", alloc_resp_valid, 0);
    checkOutput("chk_rst_cam_wr_en", cam_wr_en, 0);
    rst = 1'b0;
    resetModel();
    step();

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 50) : $urandom_range(0, 1024);
        if ($urandom_range(0, 9) == 0) begin
          k = -1;
          for (int j = 0; j < NCU; j++) if (k < 0 && ref_free[j] < s) k = j;
          if (k >= 0) begin
            ovr_mask = '0;
            ovr_mask[k] = 1'b1;
            ovr_en = 1'b1;
          end
        end
        applyStimulus(1, s, 0, 0, 0);
        ovr_en = 1'b0;
      end else if (r <= 7) begin
        applyStimulus(0, 0, 1, $urandom_range(0, 7), $urandom_range(0, 600));
      end else if (r == 8) begin
        applyStimulus(1, $urandom_range(0, 1024), 1, $urandom_range(0, 7), $urandom_range(0, 600));
      end else begin
        ovr_mask = '0;
        ovr_en = 1'b1;
        applyStimulus(1, $urandom_range(0, 1024), 0, 0, 0);
        ovr_en = 1'b0;
      end
    end

    repeat (5) step();
    checkOutput("search_q_drained", srch_q.size(), 0);
    checkOutput("wr_q_drained", wr_q.size(), 0);
    checkOutput("resp_q_drained", resp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
